lsu_mem_port: RTL and testbench
===============================

// Module: lsu_mem_port
// PURPOSE
//  Parametrised load/store unit between the multicycle RISC-V core and the valid/ack memory channel.
//  Accepts one access per request handshake and issues it on the Address/MemWrite/MemRead channel.
//  Aligns byte strobes and write data, then extracts and extends read data. Supports XLEN 32 or 64.
//  Adds misalignment, illegal-size and bus-timeout errors. Returns exactly one response per accepted request.
// PARAMETERS
//  XLEN        32  data width, 32 or 64; memory bus width equals XLEN
//  ADDR_W      32  byte-address width
//  TIMEOUT_CYC 255 max cycles in MREQ+MWAIT before error; 0 disables the timeout
// PORTS
//  clk             input  1        clock, rising edge
//  rst             input  1        reset, asynchronous, active-low
//  req_valid       input  1        core access request valid
//  req_ready       output 1        unit idle; request accepted when req_valid&req_ready
//  req_we          input  1        1 = store, 0 = load
//  req_funct3      input  3        RISC-V funct3 size/sign code
//  req_addr        input  ADDR_W   byte address
//  req_wdata       input  XLEN     store data, right-justified
//  resp_valid      output 1        response valid; held until resp_ready
//  resp_ready      input  1        core accepts response
//  resp_rdata      output XLEN     extended load data; 0 for stores and errors
//  resp_err        output 2        0 ok, 1 misaligned, 2 timeout, 3 illegal size
//  Address         output ADDR_W   bus-aligned address, low log2(XLEN/8) bits zero
//  MemWrite        output 1        write request valid
//  Write_data      output XLEN     lane-aligned write data
//  Write_strb      output XLEN/8   byte enables
//  MemRead         output 1        read request valid
//  Mem_Req_Ack     input  1        memory accepts MemRead/MemWrite
//  Read_data       input  XLEN     read data
//  Read_data_Valid input  1        read data valid
//  Read_data_Ack   output 1        core side ready for read data
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state IDLE; req_ready=1
//   - resp_valid, MemWrite, MemRead, Read_data_Ack = 0; resp_rdata, resp_err = 0
//   - Mid-operation reset abandons the access with no response; the bench must also reset memory.
//  FSM:
//   - IDLE: on accept, latch request, then:
//     - illegal size or misaligned -> RESP with error; no bus traffic
//     - store -> MREQ; load -> MREQ
//   - MREQ: drive MemWrite (store) or MemRead (load), Address, strb, data.
//     - on Mem_Req_Ack: store -> RESP (err 0); load -> MWAIT
//   - MWAIT: Read_data_Ack=1. On Read_data_Valid, register extracted data -> RESP.
//   - RESP: resp_valid=1. On resp_ready -> IDLE; req_ready rises the following cycle.
//  Timeout:
//   - Counter clears on accept and increments each cycle in MREQ/MWAIT.
//   - When count==TIMEOUT_CYC (nonzero), go to RESP with err 2 and drop MemRead/MemWrite/Read_data_Ack.
//   - A late Read_data_Valid after timeout is ignored.
//  Sizes (funct3):
//   - 000 B, 001 H, 010 W, 100 BU, 101 HU
//   - 011 D and 110 WU are legal only when XLEN=64; otherwise err 3
//   - Stores with funct3[2]=1 give err 3.
//  Alignment: access must be naturally aligned to its size, else err 1.
//  Lanes: off = addr[log2(XLEN/8)-1:0].
//   - Write_strb = size_mask << off
//   - Write_data = store data replicated across all lanes
//   - Load data = Read_data >> (8*off), then sign- or zero-extended to XLEN
//  Latency (zero-wait memory): accept@0 -> MemRead@1 acked -> Read_data_Valid@2 -> resp_valid@3.
//   Store: resp_valid@2. Error: resp_valid@1.
//  Request inputs are sampled only at accept; later changes are ignored.
// STRUCTURE
//  Package lsu_pkg:
//   - funct3 size codes
//   - resp_err codes
//   - FSM state localparams (one-hot, 4 states)
//  Sub-module lsu_lane_align (combinational): builds strobe and replicated write data, and extracts/extends load data.
//  Top: FSM, request latches, timeout counter, response registers.
// TESTING
//  XLEN=32, LW addr 0x104, memory holds 0x8000_00F1 -> resp_rdata 0x8000_00F1, err 0, resp_valid 3 cycles after accept.
//  XLEN=32, LB addr 0x103, word 0x80FF_0000 -> rdata 0xFFFF_FF80; LBU same -> 0x0000_0080.
//  XLEN=32, SH addr 0x202, wdata 0x1234_ABCD -> Write_strb 4'b1100, Write_data 0xABCD_ABCD, Address 0x200.
//  LW addr 0x106 -> err 1 next cycle; MemRead never asserted. XLEN=32 funct3 011 -> err 3.
//  TIMEOUT_CYC=4, Mem_Req_Ack held 0 -> MemRead drops and err 2 appears after 4 cycles in MREQ.
//   A later Read_data_Valid produces no second response.
//  XLEN=64, LD addr 0x8 -> 64-bit data returned. rst pulsed low in MWAIT -> IDLE, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, response
// error codes, one-hot FSM encoding and request decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_MREQ  = 4'b0010;
    localparam logic [3:0] ST_MWAIT = 4'b0100;
    localparam logic [3:0] ST_RESP  = 4'b1000;

    typedef enum logic [3:0] {
        S_IDLE  = ST_IDLE,
        S_MREQ  = ST_MREQ,
        S_MWAIT = ST_MWAIT,
        S_RESP  = ST_RESP
    } lsu_state_e;

    // Unsigned stores and the 64-bit-only sizes are rejected here.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we,
                                        input logic is64);
        logic ill;
        case (f3)
            F3_B, F3_H, F3_W: ill = 1'b0;
            F3_D:             ill = !is64;
            F3_BU, F3_HU:     ill = we;
            F3_WU:            ill = we || !is64;
            default:          ill = 1'b1;
        endcase
        return ill;
    endfunction

    function automatic logic misaligned(input logic [1:0] size_log2,
                                        input logic [2:0] addr_lo);
        logic mis;
        case (size_log2)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            2'd2:    mis = |addr_lo[1:0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_port_lane_align.sv
// Combinational lane steering: byte strobes and replicated store data on the
// way out, shift-down and sign/zero extension of load data on the way back.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic [NB-1:0]    strb,
    output logic [XLEN-1:0]  wdata_rep,
    output logic [XLEN-1:0]  rdata_ext
);

    localparam logic [XLEN-1:0] ONE = XLEN'(1);

    logic [7:0]      mask8;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] msb;
    logic [6:0]      nbits;
    logic            sign_bit;

    always_comb begin
        case (funct3[1:0])
            2'd0:    mask8 = 8'h01;
            2'd1:    mask8 = 8'h03;
            2'd2:    mask8 = 8'h0F;
            default: mask8 = 8'hFF;
        endcase
    end

    assign strb = mask8[NB-1:0] << off;

    // Each lane carries the store byte that belongs at that position for the
    // access size, so any naturally aligned offset sees the right data.
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] lane_byte;
        always_comb begin
            case (funct3[1:0])
                2'd0:    lane_byte = wdata[7:0];
                2'd1:    lane_byte = wdata[8*(gi%2) +: 8];
                2'd2:    lane_byte = wdata[8*(gi%4) +: 8];
                default: lane_byte = wdata[8*(gi%8) +: 8];
            endcase
        end
        assign wdata_rep[8*gi +: 8] = lane_byte;
    end

    assign shifted = rdata >> {off, 3'b000};

    // keep masks the access width; its top bit selects the sign source.
    always_comb begin
        nbits = 7'd8 << funct3[1:0];
        if (nbits >= 7'(XLEN)) begin
            keep = '1;
        end else begin
            keep = (ONE << nbits) - ONE;
        end
        msb       = keep & ~(keep >> 1);
        sign_bit  = (|(shifted & msb)) & ~funct3[2];
        rdata_ext = (shifted & keep) | (sign_bit ? ~keep : '0);
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit bridging the core request/response handshake to the
// valid/ack memory channel, with alignment, size and timeout checking.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [1:0]          resp_err,
    output logic [ADDR_W-1:0]   Address,
    output logic                MemWrite,
    output logic [XLEN-1:0]     Write_data,
    output logic [XLEN/8-1:0]   Write_strb,
    output logic                MemRead,
    input  logic                Mem_Req_Ack,
    input  logic [XLEN-1:0]     Read_data,
    input  logic                Read_data_Valid,
    output logic                Read_data_Ack
);

    localparam int   NB    = XLEN / 8;
    localparam int   OFF_W = $clog2(NB);
    localparam int   CNT_W = $clog2(TIMEOUT_CYC + 2);
    localparam logic IS64  = (XLEN == 64);
    localparam logic TO_EN = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    lsu_state_e        state_reg;
    logic              we_reg;
    logic [2:0]        f3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic [XLEN-1:0]   resp_rdata_reg;
    logic [1:0]        resp_err_reg;
    logic              mem_write_reg;
    logic              mem_read_reg;
    logic              rd_ack_reg;

    logic              accept;
    logic              req_illegal;
    logic              req_misaligned;
    logic              timeout_hit;
    logic [XLEN-1:0]   rdata_ext;

    assign accept         = req_valid && req_ready_reg;
    assign req_illegal    = f3_illegal(req_funct3, req_we, IS64);
    assign req_misaligned = misaligned(req_funct3[1:0], req_addr[2:0]);
    assign timeout_hit    = TO_EN && (cnt_reg == CNT_LAST);

    lsu_lane_align #(.XLEN(XLEN)) u_align (
        .funct3    (f3_reg),
        .off       (addr_reg[OFF_W-1:0]),
        .wdata     (wdata_reg),
        .rdata     (Read_data),
        .strb      (Write_strb),
        .wdata_rep (Write_data),
        .rdata_ext (rdata_ext)
    );

    assign Address       = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign req_ready     = req_ready_reg;
    assign resp_valid    = resp_valid_reg;
    assign resp_rdata    = resp_rdata_reg;
    assign resp_err      = resp_err_reg;
    assign MemWrite      = mem_write_reg;
    assign MemRead       = mem_read_reg;
    assign Read_data_Ack = rd_ack_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            we_reg         <= 1'b0;
            f3_reg         <= F3_B;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            resp_err_reg   <= ERR_OK;
            mem_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            rd_ack_reg     <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        we_reg         <= req_we;
                        f3_reg         <= req_funct3;
                        addr_reg       <= req_addr;
                        wdata_reg      <= req_wdata;
                        cnt_reg        <= '0;
                        req_ready_reg  <= 1'b0;
                        resp_rdata_reg <= '0;
                        if (req_illegal || req_misaligned) begin
                            resp_err_reg   <= req_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= S_RESP;
                        end else begin
                            mem_write_reg <= req_we;
                            mem_read_reg  <= !req_we;
                            state_reg     <= S_MREQ;
                        end
                    end
                end
                S_MREQ: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (Mem_Req_Ack) begin
                        mem_write_reg <= 1'b0;
                        mem_read_reg  <= 1'b0;
                        cnt_reg       <= cnt_reg + 1'b1;
                        if (we_reg) begin
                            resp_err_reg   <= ERR_OK;
                            resp_valid_reg <= 1'b1;
                            state_reg      <= S_RESP;
                        end else begin
                            rd_ack_reg <= 1'b1;
                            state_reg  <= S_MWAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_write_reg  <= 1'b0;
                        mem_read_reg   <= 1'b0;
                        resp_err_reg   <= ERR_TIMEOUT;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_MWAIT: begin
                    if (Read_data_Valid) begin
                        rd_ack_reg     <= 1'b0;
                        resp_rdata_reg <= rdata_ext;
                        resp_err_reg   <= ERR_OK;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= S_RESP;
                    end else if (timeout_hit) begin
                        rd_ack_reg     <= 1'b0;
                        resp_err_reg   <= ERR_TIMEOUT;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= S_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        resp_rdata_reg <= '0;
                        resp_err_reg   <= ERR_OK;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= S_IDLE;
                    end
                end
                default: begin
                    mem_write_reg  <= 1'b0;
                    mem_read_reg   <= 1'b0;
                    rd_ack_reg     <= 1'b0;
                    resp_valid_reg <= 1'b0;
                    req_ready_reg  <= 1'b1;
                    state_reg      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench: a 32-bit unit with a short timeout and a 64-bit unit, each
// behind a small zero-wait memory model.
module tb_lsu_mem_port;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---- 32-bit instance (TIMEOUT_CYC=4) ----
    logic        req_valid_a = 0, req_we_a = 0, resp_ready_a = 0;
    logic [2:0]  req_funct3_a = 0;
    logic [31:0] req_addr_a = 0, req_wdata_a = 0;
    logic        req_ready_a, resp_valid_a, MemWrite_a, MemRead_a, Read_data_Ack_a;
    logic [31:0] resp_rdata_a, Address_a, Write_data_a, Read_data_a;
    logic [1:0]  resp_err_a;
    logic [3:0]  Write_strb_a;
    logic        Mem_Req_Ack_a, Read_data_Valid_a;
    logic        ack_en_a = 1, rd_hold_a = 0, rv_force_a = 0, rv_a;
    logic [31:0] mem_a [16];

    // ---- 64-bit instance ----
    logic        req_valid_b = 0, req_we_b = 0, resp_ready_b = 0;
    logic [2:0]  req_funct3_b = 0;
    logic [31:0] req_addr_b = 0;
    logic [63:0] req_wdata_b = 0;
    logic        req_ready_b, resp_valid_b, MemWrite_b, MemRead_b, Read_data_Ack_b;
    logic [63:0] resp_rdata_b, Write_data_b, Read_data_b;
    logic [31:0] Address_b;
    logic [1:0]  resp_err_b;
    logic [7:0]  Write_strb_b;
    logic        Mem_Req_Ack_b, Read_data_Valid_b, rv_b;
    logic [63:0] mem_b [4];

    lsu_mem_port #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_we(req_we_a),
        .req_funct3(req_funct3_a), .req_addr(req_addr_a), .req_wdata(req_wdata_a),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
        .Address(Address_a), .MemWrite(MemWrite_a), .Write_data(Write_data_a),
        .Write_strb(Write_strb_a), .MemRead(MemRead_a), .Mem_Req_Ack(Mem_Req_Ack_a),
        .Read_data(Read_data_a), .Read_data_Valid(Read_data_Valid_a),
        .Read_data_Ack(Read_data_Ack_a)
    );

    lsu_mem_port #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(255)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
        .req_funct3(req_funct3_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .Address(Address_b), .MemWrite(MemWrite_b), .Write_data(Write_data_b),
        .Write_strb(Write_strb_b), .MemRead(MemRead_b), .Mem_Req_Ack(Mem_Req_Ack_b),
        .Read_data(Read_data_b), .Read_data_Valid(Read_data_Valid_b),
        .Read_data_Ack(Read_data_Ack_b)
    );

    // Zero-wait memories: combinational request ack, read data one cycle later.
    assign Mem_Req_Ack_a     = ack_en_a && (MemRead_a || MemWrite_a);
    assign Read_data_Valid_a = rv_a || rv_force_a;
    assign Mem_Req_Ack_b     = MemRead_b || MemWrite_b;
    assign Read_data_Valid_b = rv_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_a <= 1'b0;
            Read_data_a <= '0;
        end else if (MemRead_a && Mem_Req_Ack_a && !rd_hold_a) begin
            rv_a <= 1'b1;
            Read_data_a <= mem_a[Address_a[5:2]];
        end else if (rv_a && Read_data_Ack_a) begin
            rv_a <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_b <= 1'b0;
            Read_data_b <= '0;
        end else if (MemRead_b && Mem_Req_Ack_b) begin
            rv_b <= 1'b1;
            Read_data_b <= mem_b[Address_b[4:3]];
        end else if (rv_b && Read_data_Ack_b) begin
            rv_b <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full transaction; lat counts cycles from accept to resp_valid.
    task automatic run_req(input bit b64, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [63:0] wd,
                           output logic [63:0] rdata, output logic [1:0] err,
                           output int lat, output int rd_cycles,
                           output logic [7:0] strb, output logic [63:0] wdat,
                           output logic [31:0] waddr);
        bit found = 0;
        rdata = '0; err = '0; lat = 0; rd_cycles = 0; strb = '0; wdat = '0; waddr = '0;
        @(negedge clk);
        if (b64) begin
            req_valid_b = 1; req_we_b = we; req_funct3_b = f3; req_addr_b = addr; req_wdata_b = wd;
        end else begin
            req_valid_a = 1; req_we_a = we; req_funct3_a = f3; req_addr_a = addr; req_wdata_a = wd[31:0];
        end
        @(posedge clk);
        #1;
        req_valid_a = 0; req_valid_b = 0;
        req_addr_a = 32'hFFFF_FFFF; req_funct3_a = 3'b111; req_wdata_a = '0;
        req_addr_b = 32'hFFFF_FFFF; req_funct3_b = 3'b111; req_wdata_b = '0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            lat++;
            if (b64 ? MemRead_b : MemRead_a) rd_cycles++;
            if (b64 ? MemWrite_b : MemWrite_a) begin
                strb  = b64 ? Write_strb_b : {4'b0, Write_strb_a};
                wdat  = b64 ? Write_data_b : {32'b0, Write_data_a};
                waddr = b64 ? Address_b : Address_a;
            end
            if (b64 ? resp_valid_b : resp_valid_a) found = 1;
        end
        check("resp_seen", {63'b0, found}, 64'd1);
        rdata = b64 ? resp_rdata_b : {32'b0, resp_rdata_a};
        err   = b64 ? resp_err_b : resp_err_a;
        resp_ready_a = !b64; resp_ready_b = b64;
        @(posedge clk);
        #1;
        resp_ready_a = 0; resp_ready_b = 0;
        @(negedge clk);
        check("req_ready_after_resp", {63'b0, (b64 ? req_ready_b : req_ready_a)}, 64'd1);
        $display("txn x%0d we=%0d f3=%0d addr=%h rdata=%h err=%0d lat=%0d",
                 b64 ? 64 : 32, we, f3, addr, rdata, err, lat);
    endtask

    logic [63:0] rd, wdat;
    logic [1:0]  err;
    logic [7:0]  strb;
    logic [31:0] waddr;
    int          lat, rdc;
    bit          late_resp;

    initial begin
        for (int i = 0; i < 16; i++) mem_a[i] = 32'h0;
        mem_a[0] = 32'h80FF_0000;
        mem_a[1] = 32'h8000_00F1;
        for (int i = 0; i < 4; i++) mem_b[i] = 64'h0;
        mem_b[1] = 64'h1122_3344_8899_AABB;

        #12;
        check("rst_req_ready", {63'b0, req_ready_a}, 64'd1);
        check("rst_resp_valid", {63'b0, resp_valid_a}, 64'd0);
        check("rst_memread", {62'b0, MemRead_a, MemWrite_a}, 64'd0);
        check("rst_rd_ack", {63'b0, Read_data_Ack_a}, 64'd0);
        check("rst_resp_data", {30'b0, resp_err_a, resp_rdata_a}, 64'd0);
        @(negedge clk);
        rst = 1;

        run_req(0, 0, 3'b010, 32'h104, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lw_rdata", rd, 64'h8000_00F1);
        check("lw_err", {62'b0, err}, 64'd0);
        check("lw_latency", 64'(lat), 64'd3);

        run_req(0, 0, 3'b000, 32'h103, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lb_rdata", rd, 64'hFFFF_FF80);
        run_req(0, 0, 3'b100, 32'h103, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lbu_rdata", rd, 64'h0000_0080);
        run_req(0, 0, 3'b001, 32'h102, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lh_rdata", rd, 64'hFFFF_80FF);
        run_req(0, 0, 3'b101, 32'h102, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lhu_rdata", rd, 64'h0000_80FF);
        run_req(0, 0, 3'b000, 32'h102, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lb_ff_rdata", rd, 64'hFFFF_FFFF);

        run_req(0, 1, 3'b001, 32'h202, 64'h1234_ABCD, rd, err, lat, rdc, strb, wdat, waddr);
        check("sh_strb", {56'b0, strb}, 64'h0C);
        check("sh_wdata", wdat, 64'hABCD_ABCD);
        check("sh_addr", {32'b0, waddr}, 64'h200);
        check("sh_latency", 64'(lat), 64'd2);
        check("sh_resp", {rd[61:0], err}, 64'd0);

        run_req(0, 1, 3'b000, 32'h201, 64'h55, rd, err, lat, rdc, strb, wdat, waddr);
        check("sb_strb", {56'b0, strb}, 64'h02);
        check("sb_wdata", wdat, 64'h5555_5555);

        run_req(0, 0, 3'b010, 32'h106, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("misalign_err", {62'b0, err}, 64'd1);
        check("misalign_latency", 64'(lat), 64'd1);
        check("misalign_no_read", 64'(rdc), 64'd0);

        run_req(0, 0, 3'b011, 32'h100, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("ld_on_32_err", {62'b0, err}, 64'd3);
        run_req(0, 1, 3'b100, 32'h100, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("store_unsigned_err", {62'b0, err}, 64'd3);

        ack_en_a = 0;
        run_req(0, 0, 3'b010, 32'h104, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("timeout_err", {62'b0, err}, 64'd2);
        check("timeout_read_cycles", 64'(rdc), 64'd4);
        check("timeout_latency", 64'(lat), 64'd5);
        check("timeout_rdata", rd, 64'd0);
        ack_en_a = 1;
        rv_force_a = 1;
        @(negedge clk);
        rv_force_a = 0;
        late_resp = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid_a) late_resp = 1;
        end
        check("late_rvalid_ignored", {63'b0, late_resp}, 64'd0);

        run_req(1, 0, 3'b011, 32'h8, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("ld64_rdata", rd, 64'h1122_3344_8899_AABB);
        check("ld64_err", {62'b0, err}, 64'd0);
        check("ld64_latency", 64'(lat), 64'd3);
        run_req(1, 0, 3'b110, 32'hC, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lwu64_rdata", rd, 64'h0000_0000_1122_3344);
        run_req(1, 0, 3'b010, 32'h8, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("lw64_rdata", rd, 64'hFFFF_FFFF_8899_AABB);

        // Reset while the 32-bit unit is parked in MWAIT.
        rd_hold_a = 1;
        @(negedge clk);
        req_valid_a = 1; req_we_a = 0; req_funct3_a = 3'b010; req_addr_a = 32'h104;
        @(posedge clk);
        #1;
        req_valid_a = 0;
        @(negedge clk);
        @(negedge clk);
        check("mwait_entered", {63'b0, Read_data_Ack_a}, 64'd1);
        rst = 0;
        #1;
        check("midrst_req_ready", {63'b0, req_ready_a}, 64'd1);
        check("midrst_outputs", {60'b0, resp_valid_a, MemRead_a, MemWrite_a, Read_data_Ack_a}, 64'd0);
        @(negedge clk);
        rst = 1;
        rd_hold_a = 0;
        late_resp = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid_a) late_resp = 1;
        end
        check("midrst_no_resp", {63'b0, late_resp}, 64'd0);
        $display("txn x32 reset-in-MWAIT req_ready=%0d resp_valid=%0d", req_ready_a, resp_valid_a);

        run_req(0, 0, 3'b010, 32'h104, 0, rd, err, lat, rdc, strb, wdat, waddr);
        check("post_rst_lw_rdata", rd, 64'h8000_00F1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
